// File: rtl/ulight_pio_pkg.sv
// Shared definitions for the ulight LED/debug PIO: register addresses and
// the bit positions of the status word read back at OUTCLEAR.
package ulight_pio_pkg;

    localparam logic [2:0] PIO_DATA       = 3'd0;
    localparam logic [2:0] PIO_BLINK_MASK = 3'd1;
    localparam logic [2:0] PIO_PERIOD     = 3'd2;
    localparam logic [2:0] PIO_OUTSET     = 3'd3;
    localparam logic [2:0] PIO_OUTCLEAR   = 3'd4;
    localparam logic [2:0] PIO_PULSE      = 3'd5;
    localparam logic [2:0] PIO_PULSE_LEN  = 3'd6;
    localparam logic [2:0] PIO_RESERVED   = 3'd7;

    // Status word layout returned by a read of PIO_OUTCLEAR.
    localparam int STAT_PHASE_BIT = 0;
    localparam int STAT_BUSY_BIT  = 1;

endpackage

// File: rtl/ulight_pio_divider.sv
// Blink phase generator: toggles phase every `period` cycles. A zero period
// parks the phase high; `load` restarts the half-period from the beginning.
module ulight_pio_divider #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] period,
    input  logic             load,
    output logic             phase
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Half-period counter; a restart wins over a wrap in the same cycle.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (load || period == '0) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == period - CNT_ONE) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/ulight_fifo_pio_led_ctrl.sv
// Avalon-MM output PIO for LEDs/test pins: static or blinking bits plus a
// one-shot pulse overlay. Outputs depend only on registers, never on the bus.
module ulight_fifo_pio_led_ctrl
    import ulight_pio_pkg::*;
#(
    parameter int               WIDTH       = 5,
    parameter int               CNT_W       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] blink_mask;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] pulse_len;
    logic [CNT_W-1:0] pulse_cnt;
    logic [WIDTH-1:0] pulse_mask;
    logic             phase;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [CNT_W-1:0] wd_cnt;
    logic             period_load;
    logic             pulse_trig;
    logic             unused_wd;

    assign wr          = chipselect && !write_n;
    assign wd          = writedata[WIDTH-1:0];
    assign wd_cnt      = writedata[CNT_W-1:0];
    assign period_load = wr && (address == PIO_PERIOD);
    assign pulse_trig  = wr && (address == PIO_PULSE) && (pulse_len != '0);
    // Upper write-data bits beyond WIDTH/CNT_W are deliberately ignored.
    assign unused_wd   = ^writedata;

    ulight_pio_divider #(
        .CNT_W (CNT_W)
    ) u_divider (
        .clk    (clk),
        .reset  (reset),
        .period (period),
        .load   (period_load),
        .phase  (phase)
    );

    // Register file: plain RW registers plus the OUTSET/OUTCLEAR bit ops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data       <= RESET_VALUE;
            blink_mask <= '0;
            period     <= '0;
            pulse_len  <= '0;
        end else if (wr) begin
            case (address)
                PIO_DATA:       data       <= wd;
                PIO_BLINK_MASK: blink_mask <= wd;
                PIO_PERIOD:     period     <= wd_cnt;
                PIO_OUTSET:     data       <= data | wd;
                PIO_OUTCLEAR:   data       <= data & ~wd;
                PIO_PULSE_LEN:  pulse_len  <= wd_cnt;
                default:        ;
            endcase
        end
    end

    // Pulse overlay: a trigger restarts the countdown and wins over expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_cnt  <= '0;
            pulse_mask <= '0;
        end else if (pulse_trig) begin
            pulse_cnt  <= pulse_len;
            pulse_mask <= wd;
        end else if (pulse_cnt != '0) begin
            pulse_cnt  <= pulse_cnt - CNT_ONE;
        end
    end

    assign pulse_busy = (pulse_cnt != '0);
    assign out_port   = (data & ~blink_mask)
                      | (data & blink_mask & {WIDTH{phase}})
                      | (pulse_busy ? pulse_mask : '0);

    // Zero-latency read mux, zero-extended to the bus width.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        readdata = '0;
        case (address)
            PIO_DATA:       readdata[WIDTH-1:0] = data;
            PIO_BLINK_MASK: readdata[WIDTH-1:0] = blink_mask;
            PIO_PERIOD:     readdata[CNT_W-1:0] = period;
            PIO_OUTSET:     readdata[WIDTH-1:0] = out_port;
            PIO_OUTCLEAR: begin
                readdata[STAT_BUSY_BIT]  = pulse_busy;
                readdata[STAT_PHASE_BIT] = phase;
            end
            PIO_PULSE:      readdata[CNT_W-1:0] = pulse_cnt;
            PIO_PULSE_LEN:  readdata[CNT_W-1:0] = pulse_len;
            default:        readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ulight_fifo_pio_led_ctrl.sv
// Self-checking bench for ulight_fifo_pio_led_ctrl (WIDTH=5, CNT_W=24,
// RESET_VALUE=5'h15). The reference model tracks elapsed edges since the
// last PERIOD write / pulse trigger and derives phase and pulse state
// arithmetically from those.
module tb_ulight_fifo_pio_led_ctrl;

    localparam int         W  = 5;
    localparam int         CW = 24;
    localparam logic [4:0] RV = 5'h15;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [4:0]  out_port;
    logic        pulse_busy;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [4:0]  m_data, m_mask, m_pmask;
    int unsigned m_period, m_plen, m_e, m_load, m_trig, m_tlen;

    ulight_fifo_pio_led_ctrl #(
        .WIDTH       (W),
        .CNT_W       (CW),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pulse_busy (pulse_busy)
    );

    always #5 clk = ~clk;

    function automatic logic m_phase();
        if (m_period == 0) return 1'b1;
        return (((m_e - m_load) / m_period) % 2) == 0;
    endfunction

    function automatic int unsigned m_rem();
        int unsigned dt;
        dt = m_e - m_trig;
        return (dt < m_tlen) ? (m_tlen - dt) : 0;
    endfunction

    function automatic logic [4:0] m_out();
        logic [4:0] ph;
        ph = {5{m_phase()}};
        return (m_data & ~m_mask) | (m_data & m_mask & ph) |
               ((m_rem() != 0) ? m_pmask : 5'b0);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {27'b0, m_data};
            3'd1:    return {27'b0, m_mask};
            3'd2:    return m_period;
            3'd3:    return {27'b0, m_out()};
            3'd4:    return {30'b0, (m_rem() != 0), m_phase()};
            3'd5:    return m_rem();
            3'd6:    return m_plen;
            default: return 32'b0;
        endcase
    endfunction

    task automatic m_apply(input logic [2:0] a, input logic [31:0] d);
        case (a)
            3'd0: m_data = d[4:0];
            3'd1: m_mask = d[4:0];
            3'd2: begin m_period = d[23:0]; m_load = m_e; end
            3'd3: m_data = m_data | d[4:0];
            3'd4: m_data = m_data & ~d[4:0];
            3'd5: if (m_plen != 0) begin
                      m_trig = m_e; m_tlen = m_plen; m_pmask = d[4:0];
                  end
            3'd6: m_plen = d[23:0];
            default: ;
        endcase
    endtask

    task automatic m_reset();
        m_data = RV; m_mask = '0; m_pmask = '0;
        m_period = 0; m_plen = 0; m_tlen = 0; m_trig = m_e; m_load = m_e;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_e++;
        if (!reset && chipselect && !write_n) m_apply(address, writedata);
        #1;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_out"},  {27'b0, out_port},   {27'b0, m_out()});
        check({tag, "_busy"}, {31'b0, pulse_busy}, {31'b0, (m_rem() != 0)});
    endtask

    task automatic check_read(input logic [2:0] a, input string tag);
        address = a;
        #1;
        check(tag, readdata, m_read(a));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input string tag);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
        check_outs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check_outs(tag);
        end
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = '0; writedata = '0;
        m_e = 0;
        m_reset();

        // Reset state.
        #1;
        check("rst_out_lit", {27'b0, out_port}, 32'h15);
        check_outs("rst");
        check_read(3'd4, "rst_status");
        check("rst_status_lit", readdata, 32'h1);
        tick();
        #2 reset = 1'b0;
        for (int a = 0; a < 8; a++) check_read(a[2:0], "rst_read");

        // Bit set / clear.
        wr(3'd0, 32'h1F, "data");
        check("data_lit", {27'b0, out_port}, 32'h1F);
        wr(3'd4, 32'h03, "clr");
        check("clr_lit", {27'b0, out_port}, 32'h1C);
        wr(3'd3, 32'h01, "set");
        check("set_lit", {27'b0, out_port}, 32'h1D);
        check_read(3'd3, "rd_outport");

        // Blinking bits[1:0], steady bits[3:2].
        wr(3'd0, 32'h0F, "bl_data");
        wr(3'd1, 32'h03, "bl_mask");
        wr(3'd2, 32'h3,  "bl_period");
        check("bl_first_lit", {27'b0, out_port}, 32'h0F);
        for (int i = 0; i < 14; i++) begin
            tick();
            check_outs("blink");
            check_read(3'd4, "blink_status");
        end
        wr(3'd2, 32'h0, "bl_stop");
        idle(4, "bl_stopped");
        check("bl_stop_lit", {27'b0, out_port}, 32'h0F);
        check_read(3'd4, "bl_stop_status");

        // Pulse overlay, countdown readback and retrigger on the last cycle.
        wr(3'd1, 32'h0, "p_mask");
        wr(3'd6, 32'h4, "p_len");
        wr(3'd0, 32'h0, "p_data");
        wr(3'd5, 32'h10, "p_trig");
        check("p_trig_lit", {27'b0, out_port}, 32'h10);
        check_read(3'd5, "p_cnt");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs("p_run");
            check_read(3'd5, "p_cnt");
        end
        check("p_last_lit", readdata, 32'h1);
        wr(3'd5, 32'h01, "p_retrig");
        check("p_retrig_lit", {27'b0, out_port}, 32'h01);
        wr(3'd6, 32'h2, "p_len_busy");
        idle(5, "p_after");
        check("p_done_lit", {31'b0, pulse_busy}, 32'h0);
        wr(3'd6, 32'h0, "p_len0");
        wr(3'd5, 32'h1F, "p_ignored");
        check_read(3'd5, "p_ignored_cnt");

        // Asynchronous reset mid-blink and mid-pulse.
        wr(3'd0, 32'h1A, "r_data");
        wr(3'd1, 32'h0A, "r_mask");
        wr(3'd2, 32'h2,  "r_period");
        wr(3'd6, 32'h9,  "r_len");
        wr(3'd5, 32'h05, "r_trig");
        idle(3, "r_run");
        #3 reset = 1'b1;
        m_reset();
        #1;
        check_outs("r_async");
        check("r_async_lit", {27'b0, out_port}, 32'h15);
        check_read(3'd4, "r_status");
        tick();
        #2 reset = 1'b0;
        check_read(3'd5, "r_pcnt");

        // Reserved address.
        wr(3'd7, 32'hFFFF_FFFF, "rsvd_wr");
        check_read(3'd7, "rsvd_rd");
        for (int a = 0; a < 7; a++) check_read(a[2:0], "rsvd_other");

        // Randomized bus traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd2) d = $urandom_range(0, 5);
            if (a == 3'd6) d = $urandom_range(0, 6);
            chipselect = ($urandom_range(0, 2) != 0);
            write_n    = ($urandom_range(0, 1) != 0);
            writedata  = d;
            check_read(a, "rnd_read");
            tick();
            check_outs("rnd");
        end
        chipselect = 1'b0; write_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
